// File: rtl/sd_dac_modulator.sv
// First-order 1-bit sigma-delta DAC modulator with zero-order-hold framing and a 1-deep input buffer.
// Optional dither (macro SD_DITHER_EN): 16-bit LFSR bit added as carry-in to the accumulator sum.
module sd_dac_modulator #(
    parameter int data_width = 10,
    parameter int osr_log2   = 4
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  enable_i,
    input  logic [data_width-1:0] sample_i,
    input  logic                  sample_valid_i,
    output logic                  sample_ready_o,
    output logic                  bit_o,
    output logic                  frame_o,
    output logic                  underrun_o,
    output logic [osr_log2-1:0]   frame_cnt_o
);

    logic [data_width-1:0] pending_q;
    logic                  pending_valid_q;
    logic [data_width-1:0] active_q;
    logic [data_width-1:0] acc_q;
    logic [osr_log2-1:0]   cnt_q;
    logic                  bit_q;
    logic                  frame_q;
    logic                  underrun_q;
    logic                  dither;
    logic                  accept;
    logic                  boundary;
    logic [data_width:0]   sum;

`ifdef SD_DITHER_EN
    logic [15:0] lfsr_q;
    logic        lfsr_fb;

    // Right-shifting Fibonacci form of taps 16,14,13,11; keeps running while idle.
    assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    assign dither  = lfsr_q[0];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            lfsr_q <= 16'hACE1;
        else if (enable_i)
            lfsr_q <= {lfsr_fb, lfsr_q[15:1]};
    end
`else
    assign dither = 1'b0;
`endif

    assign accept   = sample_valid_i && !pending_valid_q;
    assign boundary = enable_i && (cnt_q == '0);

    // Carry out of the (data_width+1)-bit sum is the output bit.
    always_comb begin
        sum = {1'b0, acc_q} + {1'b0, active_q} + (data_width + 1)'(dither);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            active_q        <= '0;
            acc_q           <= '0;
            cnt_q           <= '0;
            bit_q           <= 1'b0;
            frame_q         <= 1'b0;
            underrun_q      <= 1'b0;
        end else begin
            frame_q    <= 1'b0;
            underrun_q <= 1'b0;
            if (accept) begin
                pending_q       <= sample_i;
                pending_valid_q <= 1'b1;
            end
            if (enable_i) begin
                acc_q <= sum[data_width-1:0];
                bit_q <= sum[data_width];
                cnt_q <= cnt_q + 1'b1;
                if (boundary) begin
                    frame_q <= 1'b1;
                    // accept and load are exclusive: accept needs the buffer empty
                    if (pending_valid_q) begin
                        active_q        <= pending_q;
                        pending_valid_q <= 1'b0;
                    end else begin
                        underrun_q <= 1'b1;
                    end
                end
            end else begin
                acc_q <= '0;
                cnt_q <= '0;
                bit_q <= 1'b0;
            end
        end
    end

    assign sample_ready_o = !pending_valid_q;
    assign bit_o          = bit_q;
    assign frame_o        = frame_q;
    assign underrun_o     = underrun_q;
    assign frame_cnt_o    = cnt_q;

endmodule

// File: tb/tb_sd_dac_modulator.sv
// Bench for sd_dac_modulator (data_width=4, osr_log2=4): density table, directed corner sequences,
// and random traffic against an arithmetic reference model.
module tb_sd_dac_modulator;

    localparam int DW  = 4;
    localparam int OSR = 4;
    localparam int FULL = 1 << DW;
    localparam int FRM  = 1 << OSR;

    logic           clk_i = 1'b0;
    logic           rstn_i = 1'b0;
    logic           enable_i = 1'b0;
    logic [DW-1:0]  sample_i = '0;
    logic           sample_valid_i = 1'b0;
    logic           sample_ready_o;
    logic           bit_o;
    logic           frame_o;
    logic           underrun_o;
    logic [OSR-1:0] frame_cnt_o;

    sd_dac_modulator #(.data_width(DW), .osr_log2(OSR)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .enable_i(enable_i),
        .sample_i(sample_i), .sample_valid_i(sample_valid_i),
        .sample_ready_o(sample_ready_o), .bit_o(bit_o), .frame_o(frame_o),
        .underrun_o(underrun_o), .frame_cnt_o(frame_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_fail = 0;

    // reference model state
    int m_pend[$];
    int m_active, m_acc, m_cnt, m_bit, m_frame, m_under;

    typedef struct { int code; int ones; } dens_t;
    dens_t dens_tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend.delete();
        m_active = 0; m_acc = 0; m_cnt = 0; m_bit = 0; m_frame = 0; m_under = 0;
    endtask

    task automatic cmp_model();
        chk("model_ready", sample_ready_o, (m_pend.size() == 0));
        chk("model_frame", frame_o, m_frame);
        chk("model_underrun", underrun_o, m_under);
        chk("model_cnt", frame_cnt_o, m_cnt);
`ifndef SD_DITHER_EN
        chk("model_bit", bit_o, m_bit);
`endif
    endtask

    // One clock: advance the model from the current inputs, then compare 1 time unit after the edge.
    task automatic step();
        bit rdy;
        int s;
        rdy = (m_pend.size() == 0);
        @(posedge clk_i);
        if (enable_i) begin
            s       = m_acc + m_active;
            m_bit   = (s >= FULL);
            m_acc   = s % FULL;
            m_frame = (m_cnt == 0);
            m_under = m_frame && rdy;
            if (m_frame && !rdy) m_active = m_pend.pop_front();
            m_cnt   = (m_cnt + 1) % FRM;
        end else begin
            m_acc = 0; m_cnt = 0; m_bit = 0; m_frame = 0; m_under = 0;
        end
        if (sample_valid_i && rdy) m_pend.push_back(int'(sample_i));
        #1;
        cmp_model();
    endtask

    task automatic do_reset();
        #2 rstn_i = 1'b0;
        model_reset();
        #1;
        chk("rst_bit", bit_o, 0);
        chk("rst_frame", frame_o, 0);
        chk("rst_underrun", underrun_o, 0);
        chk("rst_ready", sample_ready_o, 1);
        chk("rst_cnt", frame_cnt_o, 0);
        #2 rstn_i = 1'b1;
    endtask

    task automatic push(input int v);
        bit done;
        done = 0;
        sample_valid_i = 1'b1;
        sample_i = DW'(v);
        for (int i = 0; i < 64 && !done; i++) begin
            if (sample_ready_o) done = 1;
            step();
        end
        sample_valid_i = 1'b0;
        chk("push_accepted", done, 1);
    endtask

    // Steps until a frame pulse that actually loaded a sample; n = cycles taken.
    task automatic wait_load(output int n);
        bit found;
        found = 0;
        n = 0;
        while (!found && n < 64) begin
            step();
            n++;
            if (frame_o && !underrun_o) found = 1;
        end
        chk("load_seen", found, 1);
    endtask

    task automatic count_ones(input int cycles, output int ones);
        ones = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            ones += int'(bit_o);
        end
    endtask

    initial begin
        int n, ones, und, stall;
        bit ok;

        dens_tbl[0] = '{5, 5};
        dens_tbl[1] = '{0, 0};
        dens_tbl[2] = '{15, 15};
        dens_tbl[3] = '{9, 9};
        dens_tbl[4] = '{1, 1};

        model_reset();
        #3;
        do_reset();

        // density table
        enable_i = 1'b1;
        for (int t = 0; t < 5; t++) begin
            push(dens_tbl[t].code);
            wait_load(n);
            count_ones(FULL, ones);
`ifndef SD_DITHER_EN
            chk($sformatf("density_code%0d", dens_tbl[t].code), ones, dens_tbl[t].ones);
`endif
        end

        // handshake: B stalls behind A until A loads
        do_reset();
        enable_i = 1'b1;
        sample_valid_i = 1'b1;
        sample_i = 4'd3;
        step();
        sample_i = 4'd9;
        stall = 0;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            step();
            if (frame_o && !underrun_o) ok = 1;
            else if (!sample_ready_o) stall++;
        end
        chk("hs_a_loaded", ok, 1);
        chk("hs_b_stalled", stall, FRM - 1);
        chk("hs_ready_at_load", sample_ready_o, 1);
        step();
        sample_valid_i = 1'b0;
        chk("hs_b_accepted", sample_ready_o, 0);
        wait_load(n);
        chk("hs_b_load_gap", n, FRM - 1);

        // underrun: single sample, three frames
        do_reset();
        enable_i = 1'b1;
        push(7);
        wait_load(n);
        und = 0;
        for (int f = 0; f < 3; f++) begin
            ones = 0;
            for (int i = 0; i < FRM; i++) begin
                step();
                ones += int'(bit_o);
                if (i < FRM - 1 || f < 2) und += int'(underrun_o);
            end
            chk($sformatf("underrun_ones_f%0d", f), ones, 7);
        end
        chk("underrun_pulses", und, 2);

        // enable gating mid-frame
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (frame_cnt_o == 4'd6) ok = 1;
            else step();
        end
        chk("gate_reached_cnt6", ok, 1);
        enable_i = 1'b0;
        step();
        chk("gate_bit", bit_o, 0);
        chk("gate_cnt", frame_cnt_o, 0);
        step();
        chk("gate_no_frame", frame_o, 0);
        enable_i = 1'b1;
        step();
        chk("reenable_frame", frame_o, 1);

        // async reset mid-frame with pending full
        do_reset();
        enable_i = 1'b1;
        push(2);
        wait_load(n);
        push(11);
        chk("pend_full", sample_ready_o, 0);
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (frame_cnt_o == 4'd8) ok = 1;
            else step();
        end
        chk("mid_reached_cnt8", ok, 1);
        do_reset();
        step();
        chk("post_rst_underrun", underrun_o, 1);
        count_ones(FULL, ones);
`ifndef SD_DITHER_EN
        chk("post_rst_zero_ones", ones, 0);
`endif

        // code 0 idle tone
        do_reset();
        enable_i = 1'b1;
        count_ones(256, ones);
`ifdef SD_DITHER_EN
        chk("dither_ones_in_range", (ones >= 1 && ones <= 16), 1);
`else
        chk("nodither_zero_ones", ones, 0);
`endif

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            enable_i       = ($urandom_range(0, 7) != 0);
            sample_valid_i = ($urandom_range(0, 2) == 0);
            sample_i       = DW'($urandom_range(0, FULL - 1));
            step();
        end
        sample_valid_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
